// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the synchronous FIFO: write-pointer input, memory read port,
// pointer/status outputs and the output word handshake.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic [ADDR_W:0]   wr_ptr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              pop;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   rd_ptr;
    logic              empty;
    logic [ADDR_W:0]   level;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              underflow;

    // The read controller is the master; the FIFO core / consumer side is the slave.
    modport master (
        input  wr_ptr, rd_en, rd_data,
        output pop, rd_addr, rd_ptr, empty, level, dout, dout_valid, underflow
    );

    modport slave (
        output wr_ptr, rd_en, rd_data,
        input  pop, rd_addr, rd_ptr, empty, level, dout, dout_valid, underflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the synchronous FIFO: owns the read pointer, drives the
// 1-cycle-latency memory and holds the output word in standard or FWFT mode.
module fifo_rd_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int FWFT   = 0
) (
    input  logic           clk,
    input  logic           arst,
    fifo_rd_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              underflow_q, underflow_d;
    logic              fetch_q, fetch_d;
    logic              empty;
    logic              pop;

    // The wrap bit makes equal pointers mean empty and MSB-only difference mean full.
    assign empty = (rd_ptr_q == bus.wr_ptr);

    always_comb begin
        pop          = 1'b0;
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        underflow_d  = 1'b0;
        fetch_d      = 1'b0;

        if (FWFT == 0) begin
            state_d     = S_EMPTY;
            pop         = bus.rd_en & ~empty;
            underflow_d = bus.rd_en & empty;
            fetch_d     = pop;
            if (fetch_q) begin
                dout_d       = bus.rd_data;
                dout_valid_d = 1'b1;
            end
        end else begin
            // A word sitting in dout has already left memory; rd_en only acknowledges it in S_VALID.
            unique case (state_q)
                S_EMPTY: begin
                    underflow_d = bus.rd_en;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    underflow_d = bus.rd_en;
                    dout_d      = bus.rd_data;
                    state_d     = S_VALID;
                end
                S_VALID: begin
                    if (bus.rd_en) begin
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                end
            endcase
            dout_valid_d = (state_d == S_VALID);
        end

        if (arst) begin
            pop = 1'b0;
        end

        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_EMPTY;
            rd_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
            fetch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            underflow_q  <= underflow_d;
            fetch_q      <= fetch_d;
        end
    end

    assign bus.pop        = pop;
    assign bus.rd_addr    = rd_ptr_q[ADDR_W-1:0];
    assign bus.rd_ptr     = rd_ptr_q;
    assign bus.empty      = empty;
    assign bus.level      = bus.wr_ptr - rd_ptr_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.underflow  = underflow_q;

    // Never read a memory slot that has not been written.
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (arst) bus.pop |-> !empty);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: one standard-mode and one FWFT instance,
// each with a 1-cycle-latency memory model and an expected-word scoreboard.
module tb_fifo_rd_ctrl;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic arst;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();
    fifo_rd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) f_if ();

    fifo_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FWFT(0)) u_std (
        .clk  (clk),
        .arst (arst),
        .bus  (s_if)
    );

    fifo_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FWFT(1)) u_fwft (
        .clk  (clk),
        .arst (arst),
        .bus  (f_if)
    );

    logic [7:0] s_mem [8];
    logic [7:0] f_mem [8];
    logic [7:0] s_exp [$];
    logic [7:0] f_exp [$];
    logic [7:0] s_next;
    logic [7:0] f_next;
    int         num_checks = 0;
    int         num_errors = 0;

    // Memory model: the word at rd_addr appears on rd_data the cycle after pop.
    always @(posedge clk) begin
        if (s_if.pop) s_if.rd_data <= s_mem[s_if.rd_addr];
        if (f_if.pop) f_if.rd_data <= f_mem[f_if.rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One cycle of stimulus: append words to each FIFO, set rd_en, then return at the negedge.
    task automatic applyStimulus(input logic s_rd, input int s_wr_n, input logic f_rd, input int f_wr_n);
        @(posedge clk);
        #1;
        for (int k = 0; k < s_wr_n; k++) begin
            s_mem[s_if.wr_ptr[ADDR_W-1:0]] = s_next;
            s_exp.push_back(s_next);
            s_next      = s_next + 8'd1;
            s_if.wr_ptr = s_if.wr_ptr + 4'd1;
        end
        for (int k = 0; k < f_wr_n; k++) begin
            f_mem[f_if.wr_ptr[ADDR_W-1:0]] = f_next;
            f_exp.push_back(f_next);
            f_next      = f_next + 8'd1;
            f_if.wr_ptr = f_if.wr_ptr + 4'd1;
        end
        s_if.rd_en = s_rd;
        f_if.rd_en = f_rd;
        @(negedge clk);
    endtask

    // Standard words are compared when dout_valid pulses; FWFT words when acknowledged.
    always @(negedge clk) begin
        if (!arst) begin
            if (s_if.dout_valid) begin
                if (s_exp.size() == 0) checkOutput("std_spurious_word", 32'd1, 32'd0);
                else                   checkOutput("std_dout", 32'(s_if.dout), 32'(s_exp.pop_front()));
            end
            if (f_if.dout_valid && f_if.rd_en) begin
                if (f_exp.size() == 0) checkOutput("fwft_spurious_word", 32'd1, 32'd0);
                else                   checkOutput("fwft_dout", 32'(f_if.dout), 32'(f_exp.pop_front()));
            end
        end
    end

    initial begin
        logic [3:0] exp_ptr;
        logic       exp_dv, exp_uf, prev_rd, prev_dv, rd;

        arst        = 1'b1;
        s_if.wr_ptr = '0;
        s_if.rd_en  = 1'b0;
        f_if.wr_ptr = '0;
        f_if.rd_en  = 1'b0;
        s_next      = 8'h00;
        f_next      = 8'h00;

        repeat (2) @(negedge clk);
        checkOutput("rst_std_rd_ptr", 32'(s_if.rd_ptr), 32'd0);
        checkOutput("rst_std_dout_valid", 32'(s_if.dout_valid), 32'd0);
        checkOutput("rst_std_underflow", 32'(s_if.underflow), 32'd0);
        checkOutput("rst_std_empty", 32'(s_if.empty), 32'd1);
        checkOutput("rst_std_dout", 32'(s_if.dout), 32'd0);
        checkOutput("rst_fwft_rd_ptr", 32'(f_if.rd_ptr), 32'd0);
        checkOutput("rst_fwft_dout_valid", 32'(f_if.dout_valid), 32'd0);
        @(posedge clk);
        #1 arst = 1'b0;

        // Standard read of three words, fourth request underflows.
        s_next = 8'hA0;
        applyStimulus(1'b0, 3, 1'b0, 0);
        checkOutput("std_level3", 32'(s_if.level), 32'd3);
        checkOutput("std_not_empty", 32'(s_if.empty), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 0, 1'b0, 0);
            checkOutput("std_pop", 32'(s_if.pop), (i < 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("std_underflow", 32'(s_if.underflow), 32'd1);
        checkOutput("std_rd_ptr3", 32'(s_if.rd_ptr), 32'd3);
        checkOutput("std_empty3", 32'(s_if.empty), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("std_underflow_pulse", 32'(s_if.underflow), 32'd0);
        checkOutput("std_dout_hold", 32'(s_if.dout), 32'hA2);
        checkOutput("std_dv_pulse", 32'(s_if.dout_valid), 32'd0);

        // FWFT single word: appears two cycles after empty falls and is held.
        f_next = 8'h5A;
        applyStimulus(1'b0, 0, 1'b0, 1);
        checkOutput("fwft_pop_first", 32'(f_if.pop), 32'd1);
        checkOutput("fwft_dv_c0", 32'(f_if.dout_valid), 32'd0);
        applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("fwft_dv_c1", 32'(f_if.dout_valid), 32'd0);
        checkOutput("fwft_pop_fetch", 32'(f_if.pop), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 1'b0, 0);
            checkOutput("fwft_dv_hold", 32'(f_if.dout_valid), 32'd1);
            checkOutput("fwft_dout_hold", 32'(f_if.dout), 32'h5A);
            checkOutput("fwft_empty_excl", 32'(f_if.empty), 32'd1);
            checkOutput("fwft_level_excl", 32'(f_if.level), 32'd0);
        end
        applyStimulus(1'b0, 0, 1'b1, 0);
        applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("fwft_dv_after_ack", 32'(f_if.dout_valid), 32'd0);
        checkOutput("fwft_no_underflow", 32'(f_if.underflow), 32'd0);

        // Asynchronous reset in the middle of traffic on both instances.
        s_next = 8'hC0;
        f_next = 8'hD0;
        applyStimulus(1'b0, 3, 1'b0, 2);
        applyStimulus(1'b1, 0, 1'b0, 0);
        checkOutput("mid_std_pop", 32'(s_if.pop), 32'd1);
        #2 arst = 1'b1;
        #1;
        checkOutput("mid_rst_std_pop", 32'(s_if.pop), 32'd0);
        checkOutput("mid_rst_std_rd_ptr", 32'(s_if.rd_ptr), 32'd0);
        checkOutput("mid_rst_std_dv", 32'(s_if.dout_valid), 32'd0);
        checkOutput("mid_rst_std_uf", 32'(s_if.underflow), 32'd0);
        checkOutput("mid_rst_fwft_pop", 32'(f_if.pop), 32'd0);
        checkOutput("mid_rst_fwft_rd_ptr", 32'(f_if.rd_ptr), 32'd0);
        checkOutput("mid_rst_fwft_dv", 32'(f_if.dout_valid), 32'd0);
        checkOutput("mid_rst_fwft_dout", 32'(f_if.dout), 32'd0);
        s_if.rd_en  = 1'b0;
        s_if.wr_ptr = '0;
        f_if.wr_ptr = '0;
        s_exp.delete();
        f_exp.delete();
        @(posedge clk);
        #1 arst = 1'b0;

        // Pointer wrap: write/read pairs carry rd_ptr through 15 -> 0.
        s_next  = 8'h10;
        exp_ptr = 4'd0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1, 1'b0, 0);
            applyStimulus(1'b1, 0, 1'b0, 0);
            checkOutput("wrap_rd_ptr", 32'(s_if.rd_ptr), 32'(exp_ptr));
            checkOutput("wrap_pop", 32'(s_if.pop), 32'd1);
            exp_ptr = exp_ptr + 4'd1;
        end
        applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("wrap_rd_ptr8", 32'(s_if.rd_ptr), 32'd8);
        checkOutput("wrap_equal_empty", 32'(s_if.empty), 32'd1);
        applyStimulus(1'b0, 8, 1'b0, 0);
        checkOutput("full_level8", 32'(s_if.level), 32'd8);
        checkOutput("full_not_empty", 32'(s_if.empty), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 0, 1'b0, 0);
            checkOutput("drain_pop", 32'(s_if.pop), 32'd1);
        end
        repeat (2) applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("drain_empty", 32'(s_if.empty), 32'd1);
        checkOutput("drain_level", 32'(s_if.level), 32'd0);
        checkOutput("drain_rd_ptr", 32'(s_if.rd_ptr), 32'd0);

        // Pop in the same cycle wr_ptr advances from one entry.
        s_next = 8'hE0;
        applyStimulus(1'b0, 1, 1'b0, 0);
        checkOutput("simul_level1", 32'(s_if.level), 32'd1);
        applyStimulus(1'b1, 1, 1'b0, 0);
        checkOutput("simul_pop", 32'(s_if.pop), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("simul_level_after", 32'(s_if.level), 32'd1);
        checkOutput("simul_not_empty", 32'(s_if.empty), 32'd0);
        checkOutput("simul_rd_ptr", 32'(s_if.rd_ptr), 32'd1);
        applyStimulus(1'b1, 0, 1'b0, 0);
        repeat (2) applyStimulus(1'b0, 0, 1'b0, 0);
        checkOutput("simul_drained", 32'(s_if.empty), 32'd1);

        // FWFT burst: rd_en held high, a word every other cycle, underflow during fetches.
        f_next  = 8'h30;
        prev_rd = 1'b0;
        prev_dv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd = (i < 9);
            applyStimulus(1'b0, 0, rd, (i == 0) ? 4 : 0);
            exp_dv = (i >= 2) && (i % 2 == 0) && (i <= 8);
            exp_uf = (i >= 1) && prev_rd && !prev_dv;
            checkOutput("burst_dv", 32'(f_if.dout_valid), 32'(exp_dv));
            checkOutput("burst_uf", 32'(f_if.underflow), 32'(exp_uf));
            prev_rd = rd;
            prev_dv = exp_dv;
        end
        checkOutput("burst_empty", 32'(f_if.empty), 32'd1);

        checkOutput("std_words_left", 32'(s_exp.size()), 32'd0);
        checkOutput("fwft_words_left", 32'(f_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end
endmodule
